// File: rtl/gig_eth_pkg.sv
// Shared constants for the gigabit Ethernet MAC: framing bytes, frame limits,
// CRC-32 parameters and the transmit state encoding.
package gig_eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;
    localparam int          MIN_FRAME_NOFCS = 60;
    localparam int          IFG_DEFAULT     = 12;

    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    // Ethernet shifts the CRC LSB first, so the engine uses the mirrored polynomial
    function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    localparam logic [31:0] CRC_POLY_REFL = bit_reverse32(CRC_POLY);

    // Transmit FSM encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREAMBLE = 3'd1;
    localparam logic [2:0] ST_SFD      = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_PAD      = 3'd4;
    localparam logic [2:0] ST_FCS      = 3'd5;
    localparam logic [2:0] ST_ABORT    = 3'd6;
    localparam logic [2:0] ST_IFG      = 3'd7;

endpackage

// File: rtl/gig_eth_crc32_d8.sv
// Combinational CRC-32 next-state for one byte per cycle (reflected form).
// Shared between the transmit and receive MAC paths.
module gig_eth_crc32_d8
    import gig_eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    // Fold the byte in LSB first, one polynomial step per bit
    always_comb begin
        crc_out = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++)
            crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY_REFL) : (crc_out >> 1);
    end

endmodule

// File: rtl/gig_eth_tx_engine.sv
// Gigabit Ethernet transmit MAC: wraps the client byte stream into a GMII
// frame with preamble/SFD, minimum-length padding, FCS and inter-frame gap.
module gig_eth_tx_engine
    import gig_eth_pkg::*;
#(
    parameter int MAX_FRAME_SIZE_STANDARD = 1522,
    parameter int MAX_FRAME_SIZE_JUMBO    = 9022,
    parameter int IFG_BYTES               = IFG_DEFAULT
) (
    input  logic       tx_clk,
    input  logic       reset,
    input  logic       conf_tx_en,
    input  logic       conf_tx_no_gen_crc,
    input  logic       conf_tx_jumbo_en,
    input  logic [7:0] mac_tx_data,
    input  logic       mac_tx_dvld,
    input  logic       mac_tx_underrun,
    output logic       mac_tx_ack,
    output logic [7:0] gmii_tx_data,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er
);

    localparam logic [13:0] MIN_BYTES = 14'(MIN_FRAME_NOFCS);
    // The IDLE cycle itself is the last gap cycle, so IFG holds one fewer
    localparam logic [7:0]  IFG_LAST  = 8'(IFG_BYTES - 2);

    logic [2:0]  state;
    logic        gen_crc;
    logic        jumbo;
    logic        dvld_low_seen;
    logic [13:0] byte_cnt;
    logic [13:0] cnt_inc;
    logic [13:0] max_bytes;
    logic [7:0]  step;
    logic [7:0]  crc_byte;
    logic [31:0] crc;
    logic [31:0] crc_next;
    logic [31:0] fcs;

    assign mac_tx_ack = (state == ST_SFD);
    assign fcs        = ~crc;
    assign cnt_inc    = (&byte_cnt) ? byte_cnt : byte_cnt + 14'd1;
    assign max_bytes  = (jumbo ? 14'(MAX_FRAME_SIZE_JUMBO) : 14'(MAX_FRAME_SIZE_STANDARD))
                      - (gen_crc ? 14'd4 : 14'd0);
    // Padding (and the end-of-data cycle that starts it) folds zeros
    assign crc_byte   = (state != ST_PAD && mac_tx_dvld) ? mac_tx_data : 8'h00;

    gig_eth_crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (crc_byte),
        .crc_out (crc_next)
    );

    // Frame sequencer: state, counters, running CRC and registered GMII outputs
    always_ff @(posedge tx_clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            gen_crc       <= 1'b0;
            jumbo         <= 1'b0;
            dvld_low_seen <= 1'b1;
            byte_cnt      <= '0;
            step          <= '0;
            crc           <= CRC_INIT;
            gmii_tx_data  <= 8'h00;
            gmii_tx_en    <= 1'b0;
            gmii_tx_er    <= 1'b0;
        end else begin
            if (!mac_tx_dvld) dvld_low_seen <= 1'b1;
            gmii_tx_er <= 1'b0;
            case (state)
                ST_IDLE: begin
                    gmii_tx_en   <= 1'b0;
                    gmii_tx_data <= 8'h00;
                    if (mac_tx_dvld && conf_tx_en && dvld_low_seen) begin
                        state         <= ST_PREAMBLE;
                        gen_crc       <= !conf_tx_no_gen_crc;
                        jumbo         <= conf_tx_jumbo_en;
                        dvld_low_seen <= 1'b0;
                        byte_cnt      <= '0;
                        step          <= 8'd1;
                        crc           <= CRC_INIT;
                        gmii_tx_en    <= 1'b1;
                        gmii_tx_data  <= PREAMBLE_BYTE;
                    end
                end
                ST_PREAMBLE: begin
                    step <= step + 8'd1;
                    if (step == 8'd7) begin
                        state        <= ST_SFD;
                        gmii_tx_data <= SFD_BYTE;
                    end else begin
                        gmii_tx_data <= PREAMBLE_BYTE;
                    end
                end
                ST_SFD, ST_DATA: begin
                    if (mac_tx_underrun || (mac_tx_dvld && cnt_inc > max_bytes)) begin
                        state        <= ST_ABORT;
                        gmii_tx_data <= 8'h00;
                        gmii_tx_er   <= 1'b1;
                    end else if (mac_tx_dvld || (gen_crc && byte_cnt < MIN_BYTES)) begin
                        state        <= mac_tx_dvld ? ST_DATA : ST_PAD;
                        gmii_tx_data <= crc_byte;
                        crc          <= crc_next;
                        byte_cnt     <= cnt_inc;
                    end else if (gen_crc) begin
                        state        <= ST_FCS;
                        gmii_tx_data <= fcs[7:0];
                        step         <= 8'd1;
                    end else begin
                        state        <= ST_IFG;
                        gmii_tx_en   <= 1'b0;
                        gmii_tx_data <= 8'h00;
                        step         <= '0;
                    end
                end
                ST_PAD: begin
                    if (byte_cnt < MIN_BYTES) begin
                        gmii_tx_data <= 8'h00;
                        crc          <= crc_next;
                        byte_cnt     <= cnt_inc;
                    end else begin
                        state        <= ST_FCS;
                        gmii_tx_data <= fcs[7:0];
                        step         <= 8'd1;
                    end
                end
                ST_FCS: begin
                    if (step == 8'd4) begin
                        state        <= ST_IFG;
                        gmii_tx_en   <= 1'b0;
                        gmii_tx_data <= 8'h00;
                        step         <= '0;
                    end else begin
                        gmii_tx_data <= fcs[{step[1:0], 3'b000} +: 8];
                        step         <= step + 8'd1;
                    end
                end
                ST_ABORT: begin
                    state        <= ST_IFG;
                    gmii_tx_en   <= 1'b0;
                    gmii_tx_data <= 8'h00;
                    step         <= '0;
                end
                ST_IFG: begin
                    if (step == IFG_LAST) state <= ST_IDLE;
                    else                  step  <= step + 8'd1;
                end
                default: begin
                    state        <= ST_IDLE;
                    gmii_tx_en   <= 1'b0;
                    gmii_tx_data <= 8'h00;
                end
            endcase
        end
    end

endmodule
